// File: rtl/swo_pkg.sv
// Shared definitions for the SWO receive path: mode encodings, decoder states
// and the default tick-counter width.
package swo_pkg;

  localparam int   SWO_CNT_W_DEFAULT = 17;
  localparam logic SWO_MODE_MANCH    = 1'b0;
  localparam logic SWO_MODE_NRZ      = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    MEAS,
    BITS,
    START,
    DATA,
    STOP
  } swo_state_t;

endpackage

// File: rtl/swo_byte_fifo.sv
// Registered first-word-fall-through byte FIFO. A push into a full FIFO is
// dropped (unless a pop frees a slot in the same cycle) and sets a sticky flag.
module swo_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign valid   = (count != '0);
  assign data    = mem[rd_ptr];
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/swo_decoder_mp.sv
// SWO receive front end: Manchester (auto-baud) or NRZ decoding of two pad
// samples per clock, feeding decoded bytes into a small valid/ready FIFO.
module swo_decoder_mp
  import swo_pkg::*;
#(
  parameter int CNT_W      = SWO_CNT_W_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_HB = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [CNT_W-1:0] baud_div,
  input  logic             swo_a,
  input  logic             swo_b,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  input  logic             byte_ready,
  output logic             overflow,
  output logic             frame_err,
  output logic [CNT_W-1:0] hb_len,
  output logic             busy
);

  localparam int TW = CNT_W + $clog2(TIMEOUT_HB + 1);

  swo_state_t       state;
  logic             prev_level;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] phase;
  logic [CNT_W-1:0] div_r;
  logic [2:0]       idx;
  logic [7:0]       shreg;

  logic             t1;
  logic             t2;
  logic             edge_det;
  logic [CNT_W-1:0] restart;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   span;
  logic [CNT_W:0]   bit_span;
  logic [CNT_W:0]   mid_thr;
  logic             midbit;
  logic [TW-1:0]    tmo_thr;
  logic             timeout;
  logic             hit;
  logic [CNT_W-1:0] phase_nxt;
  logic             push;
  logic [7:0]       push_data;

  function automatic logic [CNT_W-1:0] sat_inc2(input logic [CNT_W-1:0] v);
    logic [CNT_W:0] s;
    s = {1'b0, v} + (CNT_W+1)'(2);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  // Samples arrive as prev_level, swo_a, swo_b; an edge between a and b leaves one sample at the new level.
  assign t1       = (prev_level != swo_a);
  assign t2       = (swo_a != swo_b);
  assign edge_det = t1 || t2;
  assign restart  = t2 ? CNT_W'(1) : CNT_W'(2);
  assign cnt_nxt  = edge_det ? restart : sat_inc2(cnt);
  assign span     = {1'b0, cnt} + {{CNT_W{1'b0}}, ~t1};
  assign bit_span = {1'b0, bit_cnt} + {{CNT_W{1'b0}}, ~t1};
  assign mid_thr  = {1'b0, hb_len} + {1'b0, hb_len >> 1};
  assign midbit   = edge_det && (bit_span >= mid_thr);
  assign tmo_thr  = TW'(TIMEOUT_HB) * TW'(hb_len);
  assign timeout  = !edge_det && (TW'(cnt_nxt) > tmo_thr);

  assign hit       = (phase <= CNT_W'(2));
  assign phase_nxt = hit ? CNT_W'({1'b0, phase} + {1'b0, div_r} - (CNT_W+1)'(2))
                         : phase - CNT_W'(2);

  assign busy = (state != IDLE);

  // The completing bit is merged combinationally so the byte lands in the FIFO on the detecting edge.
  always_comb begin
    push      = 1'b0;
    push_data = shreg;
    case (state)
      BITS: if (midbit && idx == 3'd7) begin
        push      = 1'b1;
        push_data = {prev_level, shreg[6:0]};
      end
      STOP: if (hit && swo_b) push = 1'b1;
      default: ;
    endcase
  end

  // bit_cnt measures time since the last mid-bit edge, so boundary edges (about one half-bit later) fall short of 1.5 half-bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev_level <= 1'b0;
      cnt        <= '0;
      bit_cnt    <= '0;
      phase      <= '0;
      div_r      <= '0;
      idx        <= '0;
      shreg      <= '0;
      hb_len     <= '0;
      frame_err  <= 1'b0;
    end else begin
      prev_level <= swo_b;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt   <= '0;
          div_r <= baud_div;
          idx   <= '0;
          if (mode == SWO_MODE_MANCH) begin
            if (edge_det && swo_b) begin
              cnt   <= restart;
              state <= MEAS;
            end
          end else if (!swo_b) begin
            phase <= baud_div >> 1;
            state <= START;
          end
        end
        MEAS: begin
          cnt <= cnt_nxt;
          if (edge_det) begin
            hb_len  <= span[CNT_W] ? '1 : span[CNT_W-1:0];
            bit_cnt <= restart;
            idx     <= '0;
            state   <= BITS;
          end else if (&cnt) begin
            state <= IDLE;
          end
        end
        BITS: begin
          cnt <= cnt_nxt;
          if (midbit) begin
            shreg[idx] <= prev_level;
            idx        <= idx + 1'b1;
            bit_cnt    <= restart;
          end else begin
            bit_cnt <= sat_inc2(bit_cnt);
          end
          if (timeout) begin
            if (idx != 3'd0) frame_err <= 1'b1;
            idx   <= '0;
            state <= IDLE;
          end
        end
        START: begin
          phase <= phase_nxt;
          if (hit) begin
            idx   <= '0;
            state <= swo_b ? IDLE : DATA;
          end
        end
        DATA: begin
          phase <= phase_nxt;
          if (hit) begin
            shreg[idx] <= swo_b;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          phase <= phase_nxt;
          if (hit) begin
            if (!swo_b) frame_err <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  swo_byte_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (byte_ready),
    .valid    (byte_valid),
    .data     (byte_data),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_swo_decoder_mp.sv
// Directed bench for swo_decoder_mp: builds Manchester/NRZ sample streams,
// collects popped bytes and frame_err pulses, and checks against hand values.
module tb_swo_decoder_mp;

  localparam int CNT_W = 17;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [CNT_W-1:0] baud_div;
  logic             swo_a;
  logic             swo_b;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready;
  logic             overflow;
  logic             frame_err;
  logic [CNT_W-1:0] hb_len;
  logic             busy;

  int   n_cmp = 0;
  int   n_err = 0;
  int   fe_cnt = 0;
  int   fe_long = 0;
  logic fe_prev = 1'b0;
  logic [7:0] rx_q[$];
  logic       samp_q[$];

  always #5 clk = ~clk;

  swo_decoder_mp #(
    .CNT_W(CNT_W),
    .FIFO_DEPTH(4),
    .TIMEOUT_HB(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .baud_div  (baud_div),
    .swo_a     (swo_a),
    .swo_b     (swo_b),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .overflow  (overflow),
    .frame_err (frame_err),
    .hb_len    (hb_len),
    .busy      (busy)
  );

  // Record every byte handed over and every frame_err cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid && byte_ready) rx_q.push_back(byte_data);
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (frame_err && fe_prev) fe_long <= fe_long + 1;
      fe_prev <= frame_err;
    end
  end

  task automatic step(input logic a, input logic b);
    swo_a = a;
    swo_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic add_level(input logic lvl, input int n);
    repeat (n) samp_q.push_back(lvl);
  endtask

  task automatic add_manch(input int hb, input logic [7:0] val);
    for (int i = 0; i < 8; i++) begin
      add_level(val[i], hb);
      add_level(~val[i], hb);
    end
  endtask

  task automatic add_nrz(input int div, input logic [7:0] val, input logic stop);
    add_level(1'b0, div);
    for (int i = 0; i < 8; i++) add_level(val[i], div);
    add_level(stop, div);
  endtask

  task automatic apply_stimulus();
    logic a;
    logic b;
    while (samp_q.size() > 0) begin
      a = samp_q.pop_front();
      b = (samp_q.size() > 0) ? samp_q.pop_front() : a;
      step(a, b);
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_valid"}, 32'(byte_valid), 32'd0);
    check_output({tag, "_data"},  32'(byte_data),  32'd0);
    check_output({tag, "_ovf"},   32'(overflow),   32'd0);
    check_output({tag, "_ferr"},  32'(frame_err),  32'd0);
    check_output({tag, "_hb"},    32'(hb_len),     32'd0);
    check_output({tag, "_busy"},  32'(busy),       32'd0);
  endtask

  initial begin
    int rx_base;
    int fe_base;
    int fl_base;

    rst        = 1'b1;
    mode       = 1'b0;
    baud_div   = CNT_W'(16);
    swo_a      = 1'b0;
    swo_b      = 1'b0;
    byte_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check_reset_values("rst0");
    rst = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("[TB] Manchester hb=10, 0xA5 0x3C");
    rx_base = rx_q.size();
    fe_base = fe_cnt;
    add_level(1'b0, 4);
    add_level(1'b1, 10);
    add_level(1'b0, 10);
    add_manch(10, 8'hA5);
    add_manch(10, 8'h3C);
    apply_stimulus();
    check_output("m10_busy_mid", 32'(busy), 32'd1);
    add_level(1'b0, 100);
    apply_stimulus();
    check_output("m10_count", 32'(rx_q.size() - rx_base), 32'd2);
    check_output("m10_byte0", 32'(rx_q[rx_base]), 32'hA5);
    check_output("m10_byte1", 32'(rx_q[rx_base + 1]), 32'h3C);
    check_output("m10_hb", 32'(hb_len), 32'd10);
    check_output("m10_busy_end", 32'(busy), 32'd0);
    check_output("m10_ferr", 32'(fe_cnt - fe_base), 32'd0);

    $display("[TB] Manchester hb=7, 0xFF");
    rx_base = rx_q.size();
    fe_base = fe_cnt;
    add_level(1'b0, 5);
    add_level(1'b1, 7);
    add_level(1'b0, 7);
    add_manch(7, 8'hFF);
    add_level(1'b0, 100);
    apply_stimulus();
    check_output("m7_count", 32'(rx_q.size() - rx_base), 32'd1);
    check_output("m7_byte", 32'(rx_q[rx_base]), 32'hFF);
    check_output("m7_hb", 32'(hb_len), 32'd7);
    check_output("m7_busy", 32'(busy), 32'd0);
    check_output("m7_ferr", 32'(fe_cnt - fe_base), 32'd0);

    $display("[TB] NRZ div=16 false start, then 0x55 0x80");
    mode     = 1'b1;
    baud_div = CNT_W'(16);
    rx_base  = rx_q.size();
    fe_base  = fe_cnt;
    add_level(1'b1, 52);
    add_level(1'b0, 4);
    add_level(1'b1, 60);
    apply_stimulus();
    check_output("glitch_count", 32'(rx_q.size() - rx_base), 32'd0);
    check_output("glitch_ferr", 32'(fe_cnt - fe_base), 32'd0);
    check_output("glitch_busy", 32'(busy), 32'd0);
    add_nrz(16, 8'h55, 1'b1);
    add_nrz(16, 8'h80, 1'b1);
    add_level(1'b1, 64);
    apply_stimulus();
    check_output("nrz_count", 32'(rx_q.size() - rx_base), 32'd2);
    check_output("nrz_byte0", 32'(rx_q[rx_base]), 32'h55);
    check_output("nrz_byte1", 32'(rx_q[rx_base + 1]), 32'h80);
    check_output("nrz_ferr", 32'(fe_cnt - fe_base), 32'd0);

    $display("[TB] NRZ bad stop on 0x12");
    rx_base = rx_q.size();
    fe_base = fe_cnt;
    fl_base = fe_long;
    add_nrz(16, 8'h12, 1'b0);
    add_level(1'b1, 64);
    apply_stimulus();
    check_output("stop0_count", 32'(rx_q.size() - rx_base), 32'd0);
    check_output("stop0_ferr", 32'(fe_cnt - fe_base), 32'd1);
    check_output("stop0_width", 32'(fe_long - fl_base), 32'd0);
    check_output("stop0_busy", 32'(busy), 32'd0);

    $display("[TB] overflow with ready held low");
    byte_ready = 1'b0;
    baud_div   = CNT_W'(8);
    add_level(1'b1, 16);
    add_nrz(8, 8'h11, 1'b1);
    add_nrz(8, 8'h22, 1'b1);
    add_nrz(8, 8'h33, 1'b1);
    add_nrz(8, 8'h44, 1'b1);
    add_nrz(8, 8'h55, 1'b1);
    add_nrz(8, 8'h66, 1'b1);
    add_level(1'b1, 32);
    apply_stimulus();
    check_output("ovf_flag", 32'(overflow), 32'd1);
    check_output("ovf_valid", 32'(byte_valid), 32'd1);
    check_output("ovf_head", 32'(byte_data), 32'h11);
    rx_base    = rx_q.size();
    byte_ready = 1'b1;
    repeat (12) step(1'b1, 1'b1);
    check_output("drain_count", 32'(rx_q.size() - rx_base), 32'd4);
    for (int i = 0; i < 4; i++)
      check_output($sformatf("drain_byte%0d", i), 32'(rx_q[rx_base + i]), 32'((i + 1) * 8'h11));
    check_output("drain_valid", 32'(byte_valid), 32'd0);
    check_output("ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] reset mid-byte, then 0x99");
    mode = 1'b0;
    add_level(1'b0, 20);
    add_level(1'b1, 10);
    add_level(1'b0, 10);
    for (int i = 0; i < 4; i++) begin
      add_level(1'b1, 10);
      add_level(1'b0, 10);
    end
    apply_stimulus();
    check_output("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (3) step(1'b0, 1'b0);
    check_reset_values("rst1");
    rst = 1'b0;
    step(1'b0, 1'b0);
    rx_base = rx_q.size();
    fe_base = fe_cnt;
    add_level(1'b0, 4);
    add_level(1'b1, 10);
    add_level(1'b0, 10);
    add_manch(10, 8'h99);
    add_level(1'b0, 100);
    apply_stimulus();
    check_output("post_rst_count", 32'(rx_q.size() - rx_base), 32'd1);
    check_output("post_rst_byte", 32'(rx_q[rx_base]), 32'h99);
    check_output("post_rst_hb", 32'(hb_len), 32'd10);
    check_output("post_rst_ovf", 32'(overflow), 32'd0);
    check_output("post_rst_ferr", 32'(fe_cnt - fe_base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/swo_decoder_mp.md
# swo_decoder_mp

Parametrised SWO receive front end. It decodes either Manchester (auto-baud) or NRZ/UART (programmed divisor) trace from the double-rate SWO pin samples. Decoded bytes go into a small FIFO with a valid/ready upward interface. It sits between the SWO pad sampler and the packet processor, and adds overflow, framing and timeout reporting.

## Interface
Parameters:
- CNT_W, 17: width of tick counters and of the half-bit/divisor values.
- FIFO_DEPTH, 4: byte FIFO entries; power of two, ≥2.
- TIMEOUT_HB, 8: Manchester end-of-packet threshold, in half-bits.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  module clock; the pad delivers two samples per cycle.
- rst  in  1  asynchronous, active-high reset.
- mode  in  1  0 = Manchester, 1 = NRZ; sampled only in IDLE.
- baud_div  in  CNT_W  NRZ bit length in samples; ≥4; sampled only in IDLE.
- swo_a  in  1  first (earlier) sample of this cycle.
- swo_b  in  1  second (later) sample of this cycle.
- byte_valid  out  1  FIFO non-empty.
- byte_data  out  8  head byte, LSB = first received bit.
- byte_ready  in  1  pop the head when byte_valid && byte_ready.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full; cleared by rst only.
- frame_err  out  1  one-cycle pulse on an NRZ stop bit = 0, or a Manchester timeout with bit count ≠ 0.
- hb_len  out  CNT_W  last measured Manchester half-bit, in samples.
- busy  out  1  decoder not in IDLE.

Reset values: byte_valid 0, byte_data 0, overflow 0, frame_err 0, hb_len 0, busy 0. The FIFO is emptied and the state is IDLE.

## Operation
Sample stream: per cycle the order is prev_level, swo_a, swo_b.
- The tick counter counts samples at the current level since the last transition.
- No transition: cnt += 2.
- Transition only between prev_level and a: cnt = 2.
- Any transition between a and b: cnt = 1.
- The counter saturates at all-ones.
- edge = any transition in the cycle.
- pre_level = prev_level, i.e. the level before the first transition.

Manchester FSM:
- IDLE: cnt held at 0. An edge with swo_b = 1 goes to MEAS.
- MEAS: on the next edge, hb_len ← cnt + advance (tick count up to the edge), bit index ← 0, go to BITS.
- BITS, edge with count ≥ hb_len + hb_len/2 (mid-bit):
  - bit[idx] ← pre_level; counter restarts.
  - On idx = 7, push the byte and wrap idx to 0.
- BITS, edge below that threshold: boundary edge, ignored apart from restarting the counter.
- BITS, no edge with cnt > TIMEOUT_HB·hb_len (width-extended, no overflow): go to IDLE. A partial byte (idx ≠ 0) is discarded and frame_err pulses.

NRZ FSM (idle level 1; only swo_b is used for sampling):
- IDLE: swo_b = 0 goes to START, with a phase counter of baud_div/2.
- START: at mid-bit, swo_b = 1 means a false start → IDLE; otherwise go to DATA.
- DATA: sample 8 bits LSB-first, each baud_div samples apart; the phase counter decrements by 2 per cycle.
- STOP: a sample of 1 pushes the byte; a 0 discards it and pulses frame_err. Either way → IDLE.

FIFO and mode rules:
- A push when full drops the new byte and sets overflow; stored bytes are unaffected.
- Simultaneous push and pop when full: the pop happens and the push is accepted.
- Simultaneous push and pop when empty: the byte is stored, and byte_valid rises next cycle.
- A mode or baud_div change outside IDLE takes effect only after returning to IDLE.

## Timing
- Push latency: byte_valid rises in the cycle after the clock edge that detects the 8th mid-bit edge (Manchester) or the stop sample (NRZ).
- FIFO: registered, first-word-fall-through. byte_data is valid whenever byte_valid = 1 and is stable until popped.
- frame_err: asserted exactly one cycle, in the cycle after the detecting clock edge.
- rst mid-byte: the partial byte is lost, the FIFO is flushed, and overflow clears.
- Sustained throughput: 1 byte per cycle via the FIFO.

## Structure
- Shared package swo_pkg holds:
  - mode encodings (SWO_MODE_MANCH = 0, SWO_MODE_NRZ = 1);
  - the state enum (IDLE, MEAS, BITS, START, DATA, STOP);
  - default CNT_W.
- Sub-module swo_byte_fifo (DEPTH, WIDTH = 8): push/full/overflow-drop, pop/valid. It is reused by the planned parallel trace path.

## Test plan
- Manchester, half-bit 10 samples, bytes 0xA5 then 0x3C, then idle for 100 samples → FIFO yields 0xA5, 0x3C; hb_len = 10; busy falls after the timeout; no frame_err.
- Manchester, half-bit 7 (an odd value, so edges fall between a and b), byte 0xFF → 0xFF is received; the cnt = 1 path is exercised.
- NRZ, baud_div = 16, bytes 0x55 and 0x80 with valid stops → 0x55, 0x80. A glitch low of 4 samples on idle gives a false start: no byte, no error.
- NRZ, stop bit = 0 on 0x12 → no byte pushed; frame_err pulses for exactly 1 cycle.
- byte_ready held 0, FIFO_DEPTH + 2 bytes sent → the first 4 are retained in order, overflow = 1 and stays 1. Releasing ready drains exactly 4 bytes.
- rst asserted after 4 Manchester bits, then 0x99 sent → only 0x99 is output; all outputs are at reset values while rst is high.
